// File: rtl/uncache_axi_bridge_if.sv
// Single-beat AXI4 bus between the uncached-access bridge (master) and the
// memory-side slave. Only the channels and fields the bridge actually uses.
interface uncache_axi_bridge_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata_i;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata_i, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata_i, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/uncache_axi_bridge.sv
// Turns one held uncached request from the tag stage into a single-beat AXI4
// read or write, then pulses refresh for one cycle so the tag stage can release.
module uncache_axi_bridge #(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        axi_en,
    input  logic [3:0]                  axi_wsel,
    input  logic [31:0]                 axi_addr,
    input  logic [31:0]                 axi_wdata,
    output logic                        refresh,
    output logic [31:0]                 rdata,
    output logic                        resp_err,
    uncache_axi_bridge_if.master        axi
);

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  wsel_q;
    logic        aw_done_q, w_done_q, err_q;
    logic        ar_hs, r_hs, aw_hs, w_hs, b_hs;

    // IDs and rlast are don't-care with a single outstanding single-beat transaction.
    logic unused_ok;
    assign unused_ok = ^{axi.rid, axi.rlast, axi.bid};

    function automatic logic [2:0] aw_size(input logic [3:0] strb);
        case (strb)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return 3'd0;
            4'b0011, 4'b1100:                   return 3'd1;
            default:                            return 3'd2;
        endcase
    endfunction

    assign ar_hs = axi.arvalid & axi.arready;
    assign r_hs  = axi.rvalid  & axi.rready;
    assign aw_hs = axi.awvalid & axi.awready;
    assign w_hs  = axi.wvalid  & axi.wready;
    assign b_hs  = axi.bvalid  & axi.bready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (axi_en) state_d = (axi_wsel == 4'd0) ? RD_ADDR : WR_REQ;
            RD_ADDR: if (ar_hs) state_d = RD_DATA;
            RD_DATA: if (r_hs)  state_d = DONE;
            WR_REQ:  if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) state_d = WR_RESP;
            WR_RESP: if (b_hs)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        axi.arid    = AXI_ID;
        axi.arlen   = 8'd0;
        axi.arburst = 2'b01;
        axi.araddr  = 32'd0;
        axi.arsize  = 3'd0;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        axi.awid    = AXI_ID;
        axi.awlen   = 8'd0;
        axi.awburst = 2'b01;
        axi.awaddr  = 32'd0;
        axi.awsize  = 3'd0;
        axi.awvalid = 1'b0;
        axi.wlast   = 1'b1;
        axi.wdata   = 32'd0;
        axi.wstrb   = 4'd0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        refresh     = 1'b0;
        resp_err    = 1'b0;
        case (state_q)
            RD_ADDR: begin
                axi.arvalid = 1'b1;
                axi.araddr  = {addr_q[31:2], 2'b00};
                axi.arsize  = 3'd2;
            end
            RD_DATA: axi.rready = 1'b1;
            WR_REQ: begin
                // Each valid drops independently once its own handshake is done.
                axi.awvalid = ~aw_done_q;
                axi.wvalid  = ~w_done_q;
                axi.awaddr  = addr_q;
                axi.awsize  = aw_size(wsel_q);
                axi.wdata   = wdata_q;
                axi.wstrb   = wsel_q;
            end
            WR_RESP: axi.bready = 1'b1;
            DONE: begin
                refresh  = 1'b1;
                resp_err = err_q;
            end
            default: ;
        endcase
    end

    // Request is latched once on accept; later input changes are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            wsel_q    <= 4'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            if (state_q == IDLE && axi_en) begin
                addr_q    <= axi_addr;
                wdata_q   <= axi_wdata;
                wsel_q    <= axi_wsel;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
            if (r_hs) begin
                rdata_q <= axi.rdata_i;
                err_q   <= (axi.rresp != 2'b00);
            end
            if (b_hs) err_q <= (axi.bresp != 2'b00);
        end
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_uncache_axi_bridge.sv
// Directed bench for uncache_axi_bridge: a vector table of single transactions
// against a wait-programmable slave, plus reset-abort and back-to-back sequences.
module tb_uncache_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        axi_en;
    logic [3:0]  axi_wsel;
    logic [31:0] axi_addr, axi_wdata;
    logic        refresh;
    logic [31:0] rdata;
    logic        resp_err;

    uncache_axi_bridge_if bus();

    uncache_axi_bridge #(.AXI_ID(4'd1)) dut (
        .clk       (clk),
        .rst       (rst),
        .axi_en    (axi_en),
        .axi_wsel  (axi_wsel),
        .axi_addr  (axi_addr),
        .axi_wdata (axi_wdata),
        .refresh   (refresh),
        .rdata     (rdata),
        .resp_err  (resp_err),
        .axi       (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] last_rdata;

    // Wait values are absolute cycle numbers counted from the accept edge (cycle 1).
    typedef struct {
        logic [3:0]  wsel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic [1:0]  resp;
        int          ar_at, r_at, aw_at, w_at, b_at;
        logic [31:0] exp_addr;
        logic [2:0]  exp_size;
        int          exp_ref;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic slave_idle();
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata_i = 32'd0; bus.rresp = 2'd0;
        bus.rlast   = 1'b0; bus.rid    = 4'd0; bus.awready = 1'b0; bus.wready = 1'b0;
        bus.bvalid  = 1'b0; bus.bresp  = 2'd0; bus.bid     = 4'd0;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        bit   is_rd = (v.wsel == 4'd0);
        bit   ar_d = 0, r_d = 0, aw_d = 0, w_d = 0, b_d = 0;
        int   ar_n = 0, aw_n = 0, w_n = 0, stray = 0, first = 0, got_ref = 0;
        int   addr_bad = 0, size_bad = 0, data_bad = 0, hold_bad = 0;
        logic got_err = 1'b0;
        logic [31:0] got_rdata = 32'd0, exp_rd;

        @(posedge clk); #1;
        check({tag, ".idle"}, {28'd0, refresh, bus.arvalid, bus.awvalid, bus.wvalid}, 32'd0);
        axi_en = 1'b1; axi_wsel = v.wsel; axi_addr = v.addr; axi_wdata = v.wdata;
        @(posedge clk); #1;
        axi_addr = ~v.addr; axi_wdata = ~v.wdata; axi_wsel = ~v.wsel;

        for (int cyc = 1; cyc <= 60 && got_ref == 0; cyc++) begin
            if (first == 0 && (bus.arvalid || bus.awvalid || bus.wvalid)) first = cyc;
            if (bus.arvalid) begin
                ar_n++;
                if (bus.araddr !== v.exp_addr) addr_bad++;
                if (bus.arsize !== v.exp_size) size_bad++;
            end
            if (bus.awvalid) begin
                aw_n++;
                if (bus.awaddr !== v.exp_addr) addr_bad++;
                if (bus.awsize !== v.exp_size) size_bad++;
            end
            if (bus.wvalid) begin
                w_n++;
                if (bus.wdata !== v.wdata || bus.wstrb !== v.wsel || bus.wlast !== 1'b1) data_bad++;
            end
            if ((is_rd && bus.bready) || (!is_rd && bus.rready)) stray++;
            if (refresh) begin
                got_ref = cyc; got_err = resp_err; got_rdata = rdata;
                axi_en = 1'b0;
                slave_idle();
            end else begin
                if (rdata !== last_rdata) hold_bad++;
                bus.arready = !ar_d && cyc >= v.ar_at;
                bus.rvalid  = ar_d && !r_d && cyc >= v.r_at;
                bus.rdata_i = bus.rvalid ? v.rd : 32'h0BAD_0BAD;
                bus.rresp   = v.resp;
                bus.rlast   = 1'b1;
                bus.awready = !aw_d && cyc >= v.aw_at;
                bus.wready  = !w_d && cyc >= v.w_at;
                bus.bvalid  = aw_d && w_d && !b_d && cyc >= v.b_at;
                bus.bresp   = v.resp;
                if (bus.arvalid && bus.arready) ar_d = 1;
                if (bus.rvalid  && bus.rready)  r_d  = 1;
                if (bus.awvalid && bus.awready) aw_d = 1;
                if (bus.wvalid  && bus.wready)  w_d  = 1;
                if (bus.bvalid  && bus.bready)  b_d  = 1;
                @(posedge clk); #1;
            end
        end
        axi_en = 1'b0;
        slave_idle();

        exp_rd = is_rd ? v.rd : last_rdata;
        check({tag, ".first_valid"}, first, 1);
        check({tag, ".addr"}, addr_bad, 0);
        check({tag, ".size"}, size_bad, 0);
        check({tag, ".wdata_wstrb"}, data_bad, 0);
        check({tag, ".stray_ready"}, stray, 0);
        check({tag, ".ar_cycles"}, ar_n, is_rd ? v.ar_at : 0);
        check({tag, ".aw_cycles"}, aw_n, is_rd ? 0 : v.aw_at);
        check({tag, ".w_cycles"}, w_n, is_rd ? 0 : v.w_at);
        check({tag, ".refresh_cycle"}, got_ref, v.exp_ref);
        check({tag, ".resp_err"}, 32'(got_err), 32'(v.exp_err));
        check({tag, ".rdata"}, got_rdata, exp_rd);
        check({tag, ".rdata_hold"}, hold_bad, 0);
        last_rdata = exp_rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        vec_t v_a, v_b, v_c;
        int   ref_n;

        //           wsel   addr           wdata          rd             resp   ar r  aw w  b  exp_addr       sz    ref err
        vecs[0] = '{4'h0, 32'hBFAF_8004, 32'h0,        32'h1234_5678, 2'b00, 1, 1, 0, 0, 0, 32'hBFAF_8004, 3'd2, 3, 1'b0};
        vecs[1] = '{4'hF, 32'hBFAF_F000, 32'hDEAD_BEEF, 32'h0,        2'b00, 0, 0, 4, 1, 1, 32'hBFAF_F000, 3'd2, 6, 1'b0};
        vecs[2] = '{4'h4, 32'h1000_0003, 32'hA5A5_A5A5, 32'h0,        2'b00, 0, 0, 1, 1, 1, 32'h1000_0003, 3'd0, 3, 1'b0};
        vecs[3] = '{4'hC, 32'h1000_0002, 32'h0F0F_0F0F, 32'h0,        2'b00, 0, 0, 1, 1, 1, 32'h1000_0002, 3'd1, 3, 1'b0};
        vecs[4] = '{4'h0, 32'h1FC0_0007, 32'h0,        32'hCAFE_F00D, 2'b10, 3, 6, 0, 0, 0, 32'h1FC0_0004, 3'd2, 7, 1'b1};
        vecs[5] = '{4'h3, 32'h2000_0010, 32'h1122_3344, 32'h0,        2'b00, 0, 0, 2, 2, 5, 32'h2000_0010, 3'd1, 6, 1'b0};
        vecs[6] = '{4'h7, 32'h2000_0020, 32'h5566_7788, 32'h0,        2'b00, 0, 0, 1, 3, 1, 32'h2000_0020, 3'd2, 5, 1'b0};
        vecs[7] = '{4'h8, 32'h2000_0031, 32'h99AA_BBCC, 32'h0,        2'b11, 0, 0, 1, 1, 1, 32'h2000_0031, 3'd0, 3, 1'b1};
        v_a     = '{4'h0, 32'h0000_0100, 32'h0,        32'h55AA_33CC, 2'b00, 1, 1, 0, 0, 0, 32'h0000_0100, 3'd2, 3, 1'b0};
        v_b     = '{4'h0, 32'h0000_0204, 32'h0,        32'h0F1E_2D3C, 2'b00, 2, 5, 0, 0, 0, 32'h0000_0204, 3'd2, 6, 1'b0};
        v_c     = '{4'h0, 32'h0000_0302, 32'h0,        32'h7788_99AA, 2'b00, 1, 1, 0, 0, 0, 32'h0000_0300, 3'd2, 3, 1'b0};

        rst = 1'b0; axi_en = 1'b0; axi_wsel = 4'd0; axi_addr = 32'd0; axi_wdata = 32'd0;
        slave_idle();
        last_rdata = 32'd0;

        #3;
        check("reset.handshakes", {25'd0, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid,
                                   bus.bready, refresh, resp_err}, 32'd0);
        check("reset.rdata", rdata, 32'd0);
        check("reset.constants", {3'd0, bus.arid, bus.awid, bus.arlen, bus.awlen,
                                  bus.arburst, bus.awburst, bus.wlast},
              {3'd0, 4'd1, 4'd1, 8'd0, 8'd0, 2'b01, 2'b01, 1'b1});
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Abort a read while it is stalled in the data phase.
        @(posedge clk); #1;
        axi_en = 1'b1; axi_wsel = 4'd0; axi_addr = 32'h0000_0010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.arready = 1'b1;
        @(posedge clk); #1;
        bus.arready = 1'b0;
        check("abort.in_rd_data", 32'(bus.rready), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort.outputs", {25'd0, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid,
                                bus.bready, refresh, resp_err}, 32'd0);
        check("abort.rdata", rdata, 32'd0);
        axi_en = 1'b0;
        bus.rvalid = 1'b1; bus.rdata_i = 32'hFFFF_0000;
        ref_n = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (refresh) ref_n++;
        end
        check("abort.no_refresh", ref_n, 0);
        check("abort.rdata_kept_zero", rdata, 32'd0);
        slave_idle();
        rst = 1'b1;
        last_rdata = 32'd0;

        run_txn(v_a, "after_reset");
        run_txn(v_b, "b2b_first");
        run_txn(v_c, "b2b_second");

        ref_n = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (refresh || bus.arvalid) ref_n++;
        end
        check("b2b.no_replay", ref_n, 0);
        check("b2b.rdata_final", rdata, 32'h7788_99AA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
